// File: rtl/rc4_engine_if.sv
// Bundle of the RC4 engine's control handshake and its three memory ports.
// master = engine side, slave = the environment that owns key, control and memories.
interface rc4_engine_if #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_AW    = 5
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] key;
    logic                   busy;
    logic                   done;
    logic [1:0]             phase;
    logic [7:0]             s_addr;
    logic [7:0]             s_wdata;
    logic                   s_wren;
    logic [7:0]             s_q;
    logic [MSG_AW-1:0]      m_addr;
    logic [7:0]             m_q;
    logic [MSG_AW-1:0]      d_addr;
    logic [7:0]             d_wdata;
    logic                   d_wren;

    modport master (
        input  start, key, s_q, m_q,
        output busy, done, phase, s_addr, s_wdata, s_wren, m_addr, d_addr, d_wdata, d_wren
    );

    modport slave (
        output start, key, s_q, m_q,
        input  busy, done, phase, s_addr, s_wdata, s_wren, m_addr, d_addr, d_wdata, d_wren
    );
endinterface

// File: rtl/rc4_engine.sv
// RC4 engine: S-box init, key schedule and keystream decryption run as one sequenced
// operation over single-port S RAM, message ROM and result RAM (all 1-cycle read latency).
module rc4_engine #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned MSG_AW    = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    rc4_engine_if.master bus
);
    localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [MSG_AW-1:0] K_LAST    = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        StIdle, StInit,
        StKRdi, StKWi, StKSum, StKRdj, StKWj, StKWri, StKWrj,
        StPInc, StPRdi, StPWi, StPSum, StPRdj, StPWj, StPWri, StPWrj, StPRdf, StPXor,
        StDone
    } state_e;

    state_e             r_state, w_state_next;
    logic [7:0]         r_i, w_i_next;
    logic [7:0]         r_j, w_j_next;
    logic [7:0]         r_si, w_si_next;
    logic [7:0]         r_sj, w_sj_next;
    logic [MSG_AW-1:0]  r_k, w_k_next;
    logic [KIDX_W-1:0]  r_kidx, w_kidx_next;
    logic [8*KEY_BYTES-1:0] w_key_shift;
    logic [7:0]         w_key_byte;
    logic [7:0]         w_ks_addr;

    // Key byte 0 sits in the most significant byte of the key vector.
    assign w_key_shift = bus.key >> (32'd8 * (32'(KEY_BYTES - 1) - 32'(r_kidx)));
    assign w_key_byte  = w_key_shift[7:0];
    assign w_ks_addr   = r_si + r_sj;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_k     <= '0;
            r_kidx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_i     <= w_i_next;
            r_j     <= w_j_next;
            r_si    <= w_si_next;
            r_sj    <= w_sj_next;
            r_k     <= w_k_next;
            r_kidx  <= w_kidx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_i_next     = r_i;
        w_j_next     = r_j;
        w_si_next    = r_si;
        w_sj_next    = r_sj;
        w_k_next     = r_k;
        w_kidx_next  = r_kidx;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        bus.s_wren   = 1'b0;
        bus.m_addr   = '0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.d_wren   = 1'b0;
        bus.busy     = (r_state != StIdle);
        bus.done     = (r_state == StDone);

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StInit;
                    w_i_next     = '0;
                end
            end
            StInit: begin
                bus.s_addr  = r_i;
                bus.s_wdata = r_i;
                bus.s_wren  = 1'b1;
                w_i_next    = r_i + 8'd1;
                if (r_i == 8'hFF) begin
                    w_state_next = StKRdi;
                    w_j_next     = '0;
                    w_kidx_next  = '0;
                end
            end
            // Read addresses are held through the wait state so s_q stays valid.
            StKRdi: begin bus.s_addr = r_i; w_state_next = StKWi; end
            StKWi:  begin bus.s_addr = r_i; w_state_next = StKSum; end
            StKSum: begin
                bus.s_addr   = r_i;
                w_si_next    = bus.s_q;
                w_j_next     = r_j + bus.s_q + w_key_byte;
                w_state_next = StKRdj;
            end
            StKRdj: begin bus.s_addr = r_j; w_state_next = StKWj; end
            StKWj:  begin bus.s_addr = r_j; w_state_next = StKWri; end
            StKWri: begin
                bus.s_addr   = r_i;
                bus.s_wdata  = bus.s_q;
                bus.s_wren   = 1'b1;
                w_sj_next    = bus.s_q;
                w_state_next = StKWrj;
            end
            StKWrj: begin
                bus.s_addr   = r_j;
                bus.s_wdata  = r_si;
                bus.s_wren   = 1'b1;
                w_i_next     = r_i + 8'd1;
                w_kidx_next  = (r_kidx == KIDX_LAST) ? '0 : r_kidx + KIDX_W'(1);
                w_state_next = StKRdi;
                if (r_i == 8'hFF) begin
                    w_state_next = StPInc;
                    w_j_next     = '0;
                    w_k_next     = '0;
                end
            end
            StPInc: begin w_i_next = r_i + 8'd1; w_state_next = StPRdi; end
            StPRdi: begin bus.s_addr = r_i; w_state_next = StPWi; end
            StPWi:  begin bus.s_addr = r_i; w_state_next = StPSum; end
            StPSum: begin
                bus.s_addr   = r_i;
                w_si_next    = bus.s_q;
                w_j_next     = r_j + bus.s_q;
                w_state_next = StPRdj;
            end
            StPRdj: begin bus.s_addr = r_j; w_state_next = StPWj; end
            StPWj:  begin bus.s_addr = r_j; w_state_next = StPWri; end
            StPWri: begin
                bus.s_addr   = r_i;
                bus.s_wdata  = bus.s_q;
                bus.s_wren   = 1'b1;
                w_sj_next    = bus.s_q;
                w_state_next = StPWrj;
            end
            StPWrj: begin
                bus.s_addr   = r_j;
                bus.s_wdata  = r_si;
                bus.s_wren   = 1'b1;
                w_state_next = StPRdf;
            end
            StPRdf: begin
                bus.s_addr   = w_ks_addr;
                bus.m_addr   = r_k;
                w_state_next = StPXor;
            end
            StPXor: begin
                bus.s_addr   = w_ks_addr;
                bus.m_addr   = r_k;
                bus.d_addr   = r_k;
                bus.d_wdata  = bus.s_q ^ bus.m_q;
                bus.d_wren   = 1'b1;
                w_k_next     = r_k + MSG_AW'(1);
                w_state_next = (r_k == K_LAST) ? StDone : StPInc;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.phase = 2'd3;
        unique case (r_state)
            StIdle: bus.phase = 2'd0;
            StInit: bus.phase = 2'd1;
            StKRdi, StKWi, StKSum, StKRdj, StKWj, StKWri, StKWrj: bus.phase = 2'd2;
            default: bus.phase = 2'd3;
        endcase
    end
endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine: four instances (different key/message sizes) with behavioural
// memories, a plain-arithmetic RC4 model and a per-cycle output compare.
module tb_rc4_engine;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic        start [NI];
    logic [31:0] key   [NI];
    logic [7:0]  m_rom [NI][32];

    logic       mon_busy [NI], mon_done [NI], mon_s_wren [NI], mon_d_wren [NI];
    logic [1:0] mon_phase [NI];
    logic [7:0] mon_s_addr [NI], mon_s_wdata [NI], mon_d_wdata [NI];
    logic [4:0] mon_d_addr [NI], mon_m_addr [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned KB = (g == 1) ? 4 : 3;
        localparam int unsigned ML = (g == 0) ? 9 : (g == 1) ? 5 : (g == 2) ? 32 : 1;
        rc4_engine_if #(.KEY_BYTES(KB), .MSG_AW(5)) bus ();
        logic [7:0] s_mem [256];
        logic [7:0] r_s_q, r_m_q;

        assign bus.start = start[g];
        assign bus.key   = key[g][8*KB-1:0];
        assign bus.s_q   = r_s_q;
        assign bus.m_q   = r_m_q;

        always @(posedge clk) begin
            if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
            r_s_q <= s_mem[bus.s_addr];
            r_m_q <= m_rom[g][bus.m_addr];
        end

        assign mon_busy[g]    = bus.busy;
        assign mon_done[g]    = bus.done;
        assign mon_s_wren[g]  = bus.s_wren;
        assign mon_d_wren[g]  = bus.d_wren;
        assign mon_phase[g]   = bus.phase;
        assign mon_s_addr[g]  = bus.s_addr;
        assign mon_s_wdata[g] = bus.s_wdata;
        assign mon_d_wdata[g] = bus.d_wdata;
        assign mon_d_addr[g]  = bus.d_addr;
        assign mon_m_addr[g]  = bus.m_addr;

        rc4_engine #(.KEY_BYTES(KB), .MSG_LEN(ML), .MSG_AW(5)) u_dut (
            .i_clk   (clk),
            .i_reset (reset),
            .bus     (bus)
        );
    end

    int total = 0;
    int bad = 0;
    logic [7:0] exp_d [NI][32];
    logic [7:0] got_d [NI][32];
    logic [7:0] exp_s [256];
    logic [7:0] shadow_s [NI][256];
    int widx [NI];
    int bcnt [NI];
    int done_cnt [NI];

    logic [7:0] pt_key  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct_key  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] pt_wiki [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    logic [7:0] ct_wiki [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

    function automatic int ml_of(input int g);
        case (g)
            0: return 9;
            1: return 5;
            2: return 32;
            default: return 1;
        endcase
    endfunction

    // Phase expected from the number of busy cycles elapsed in this operation.
    function automatic logic [1:0] exp_phase(input int b);
        if (b <= 256) return 2'd1;
        if (b <= 2048) return 2'd2;
        return 2'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Textbook RC4 on plain arrays; fills exp_d[g] and the post-KSA S table.
    task automatic model_run(input int g, input logic [31:0] k, input int kb, input int n);
        logic [7:0] s [256];
        logic [7:0] t, kbyte;
        int i, j;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kbyte = 8'(k >> (8 * (kb - 1 - (x % kb))));
            j = (j + s[x] + kbyte) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        exp_s = s;
        i = 0;
        j = 0;
        for (int x = 0; x < n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_d[g][x] = m_rom[g][x] ^ s[(32'(s[i]) + 32'(s[j])) % 256];
        end
    endtask

    task automatic check_cycle();
        for (int g = 0; g < NI; g++) begin
            if (mon_busy[g] === 1'b1) bcnt[g]++;
            if (mon_s_wren[g] === 1'b1 || mon_d_wren[g] === 1'b1)
                chk("write_only_while_busy", 32'(mon_busy[g]), 1);
            if (mon_s_wren[g] === 1'b1) shadow_s[g][mon_s_addr[g]] = mon_s_wdata[g];
            if (mon_busy[g] === 1'b1 && mon_done[g] !== 1'b1)
                chk("phase", 32'(mon_phase[g]), 32'(exp_phase(bcnt[g])));
            if (mon_d_wren[g] === 1'b1) begin
                chk("d_addr", 32'(mon_d_addr[g]), widx[g]);
                chk("d_wdata", 32'(mon_d_wdata[g]), 32'(exp_d[g][widx[g] % 32]));
                if (widx[g] < 32) got_d[g][widx[g]] = mon_d_wdata[g];
                widx[g]++;
            end
            if (mon_done[g] === 1'b1) begin
                done_cnt[g]++;
                chk("done_write_count", widx[g], ml_of(g));
                chk("done_latency", bcnt[g], 2049 + 10 * ml_of(g));
                chk("done_no_write", 32'(mon_s_wren[g] | mon_d_wren[g]), 0);
            end
            if (mon_busy[g] !== 1'b1) begin
                widx[g] = 0;
                bcnt[g] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_op(input int g, input bit dump_s, output int cyc);
        logic [1:0] prev_ph;
        int errs;
        for (int n = 0; n < 32; n++) got_d[g][n] = 8'h00;
        prev_ph = 2'd0;
        start[g] = 1'b1;
        for (cyc = 1; cyc <= 5000; cyc++) begin
            tick();
            if (cyc == 1) start[g] = 1'b0;
            if (dump_s && prev_ph == 2'd1 && mon_phase[g] == 2'd2) begin
                errs = 0;
                for (int n = 0; n < 256; n++) if (shadow_s[g][n] !== 8'(n)) errs++;
                chk("s_after_init_mismatches", errs, 0);
            end
            if (dump_s && prev_ph == 2'd2 && mon_phase[g] == 2'd3) begin
                errs = 0;
                for (int n = 0; n < 256; n++) if (shadow_s[g][n] !== exp_s[n]) errs++;
                chk("s_after_ksa_mismatches", errs, 0);
            end
            prev_ph = mon_phase[g];
            if (mon_done[g] === 1'b1) break;
        end
        chk("done_seen", 32'(mon_done[g]), 1);
        tick();
    endtask

    initial begin
        int cyc, w, base;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0; key[g] = '0;
            widx[g] = 0; bcnt[g] = 0; done_cnt[g] = 0;
            for (int n = 0; n < 32; n++) m_rom[g][n] = 8'h00;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int g = 0; g < NI; g++) begin
            chk("reset_busy", 32'(mon_busy[g]), 0);
            chk("reset_phase", 32'(mon_phase[g]), 0);
        end
        chk("reset_done", 32'(mon_done[0]), 0);
        chk("reset_wren", 32'({mon_s_wren[0], mon_d_wren[0]}), 0);
        chk("reset_addr", 32'({mon_s_addr[0], mon_m_addr[0], mon_d_addr[0]}), 0);
        chk("reset_wdata", 32'({mon_s_wdata[0], mon_d_wdata[0]}), 0);

        // "Key" / "Plaintext" vector, with literal latency.
        key[0] = 32'h004B6579;
        for (int n = 0; n < 9; n++) m_rom[0][n] = ct_key[n];
        model_run(0, key[0], 3, 9);
        for (int n = 0; n < 9; n++) chk("model_plaintext", 32'(exp_d[0][n]), 32'(pt_key[n]));
        run_op(0, 1'b0, cyc);
        chk("latency_2139", cyc, 2139);
        for (int n = 0; n < 9; n++) chk("d_plaintext", 32'(got_d[0][n]), 32'(pt_key[n]));

        // All-zero key: S dumps after INIT and after KSA.
        key[0] = 32'h0;
        model_run(0, key[0], 3, 9);
        run_op(0, 1'b1, cyc);

        // Reset in the middle of KSA, then a clean rerun.
        key[0] = 32'h004B6579;
        model_run(0, key[0], 3, 9);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (699) tick();
        chk("abort_in_ksa", 32'(mon_phase[0]), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(mon_busy[0]), 0);
        chk("abort_phase", 32'(mon_phase[0]), 0);
        w = 0;
        repeat (20) begin
            tick();
            if (mon_s_wren[0] === 1'b1 || mon_d_wren[0] === 1'b1 || mon_done[0] === 1'b1) w++;
        end
        chk("activity_after_reset", w, 0);
        run_op(0, 1'b0, cyc);
        for (int n = 0; n < 9; n++) chk("rerun_plaintext", 32'(got_d[0][n]), 32'(pt_key[n]));

        // "Wiki" / "pedia" vector on the 4-byte-key instance.
        key[1] = 32'h57696B69;
        for (int n = 0; n < 5; n++) m_rom[1][n] = ct_wiki[n];
        model_run(1, key[1], 4, 5);
        for (int n = 0; n < 5; n++) chk("model_pedia", 32'(exp_d[1][n]), 32'(pt_wiki[n]));
        run_op(1, 1'b0, cyc);
        for (int n = 0; n < 5; n++) chk("d_pedia", 32'(got_d[1][n]), 32'(pt_wiki[n]));

        // Start pulsed while busy and held high through the done cycle.
        base = done_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cyc = 1;
        repeat (300) begin tick(); cyc++; end
        start[0] = 1'b1;
        tick(); cyc++;
        start[0] = 1'b0;
        while (cyc < 2130) begin tick(); cyc++; end
        start[0] = 1'b1;
        while (mon_done[0] !== 1'b1 && cyc < 3000) begin tick(); cyc++; end
        chk("held_start_done_seen", 32'(mon_done[0]), 1);
        chk("held_start_latency", cyc, 2139);
        tick();
        chk("idle_after_done", 32'(mon_busy[0]), 0);
        start[0] = 1'b0;
        repeat (10) tick();
        chk("no_restart", 32'(mon_busy[0]), 0);
        chk("single_operation", done_cnt[0] - base, 1);

        // Shortest and longest messages.
        key[3] = 32'h004B6579;
        m_rom[3][0] = 8'hBB;
        model_run(3, key[3], 3, 1);
        chk("model_len1", 32'(exp_d[3][0]), 32'h50);
        run_op(3, 1'b0, cyc);
        chk("len1_latency", cyc, 2059);
        key[2] = 32'h00A5C3E1;
        for (int n = 0; n < 32; n++) m_rom[2][n] = 8'(n * 7 + 3);
        model_run(2, key[2], 3, 32);
        run_op(2, 1'b0, cyc);
        chk("len32_latency", cyc, 2369);
        repeat (5) tick();
        chk("len1_single_done", done_cnt[3], 1);
        chk("len32_single_done", done_cnt[2], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
